// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage of the 5-stage pipeline. It performs the ALU operation,
//   resolves branches and jumps, and registers the results into the
//   execute-to-memory pipeline register. Decode cannot be flushed, so this
//   stage squashes the SQUASH_SLOTS wrong-path instructions that follow a
//   redirect.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   RegWriteE .. ALUSrcE       decode-register control bits
//   ResultSrcE [1:0]           result select (00 ALU, 01 mem, 10 PC+1)
//   ALUControlE [2:0]          ALU operation
//   RD1E, RD2E, ImmExtE [18:0] operand A, operand B / store data, immediate
//   PCE [14:0], RDE [4:0]      PC and destination of the E instruction
//   FlushE                     hazard-unit bubble request
//   PCSrcE, PCTargetE          combinational fetch redirect
//   *M outputs                 execute-to-memory pipeline register
module execute_stage #(
  parameter int SQUASH_SLOTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [18:0] RD1E,
  input  logic [18:0] RD2E,
  input  logic [18:0] ImmExtE,
  input  logic [14:0] PCE,
  input  logic [4:0]  RDE,
  input  logic        FlushE,
  output logic        PCSrcE,
  output logic [14:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [18:0] ALUResultM,
  output logic [18:0] WriteDataM,
  output logic [14:0] PCPlus1M,
  output logic [4:0]  RdM
);

  logic [18:0] src_a;
  logic [18:0] src_b;
  logic [18:0] alu_result;
  logic [18:0] cmp_diff;
  logic [4:0]  shamt;
  logic        zero;
  logic        slt;
  logic        kill;
  logic [14:0] pc_plus1;
  logic [1:0]  squash_cnt;

  assign src_a = RD1E;
  assign src_b = ALUSrcE ? ImmExtE : RD2E;
  assign shamt = src_b[4:0];
  assign slt   = $signed(src_a) < $signed(src_b);

  // Branch compare has its own subtractor so ZeroE does not depend on the
  // ALU operation selected for this instruction.
  assign cmp_diff = src_a - src_b;
  assign zero     = (cmp_diff == 19'd0);

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      // Shift amounts of 19..31 would shift everything out; force 0 explicitly.
      3'b101:  alu_result = (shamt >= 5'd19) ? 19'd0 : (src_a << shamt);
      3'b110:  alu_result = (shamt >= 5'd19) ? 19'd0 : (src_a >> shamt);
      default: alu_result = {18'd0, slt};
    endcase
  end

  assign pc_plus1  = PCE + 15'd1;
  assign PCTargetE = PCE + ImmExtE[14:0];

  // A squashed branch/jump must neither redirect nor reload the counter.
  assign kill   = FlushE | (squash_cnt != 2'd0);
  assign PCSrcE = ~kill & (JumpE | (BranchE & zero));

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_cnt <= 2'd0;
    end else if (PCSrcE) begin
      squash_cnt <= 2'(SQUASH_SLOTS);
    end else if (squash_cnt != 2'd0) begin
      squash_cnt <= squash_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus1M   <= '0;
      RdM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result;
      WriteDataM <= RD2E;
      PCPlus1M   <= pc_plus1;
      RdM        <= RDE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [18:0] RD1E, RD2E, ImmExtE;
  logic [14:0] PCE;
  logic [4:0]  RDE;
  logic        FlushE;
  logic        PCSrcE;
  logic [14:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [18:0] ALUResultM, WriteDataM;
  logic [14:0] PCPlus1M;
  logic [4:0]  RdM;

  int n_assert = 0;
  int n_fail   = 0;

  execute_stage #(.SQUASH_SLOTS(2)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .RDE(RDE), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus1M(PCPlus1M),
    .RdM(RdM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = 2'b00; ALUControlE = 3'b000;
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; RDE = '0; FlushE = 0;
  endtask

  task automatic rand_inputs();
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); JumpE = 1'($urandom);
    BranchE = 1'($urandom); ALUSrcE = 1'($urandom);
    ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom);
    RD1E = 19'($urandom); RD2E = 19'($urandom); ImmExtE = 19'($urandom);
    PCE = 15'($urandom); RDE = 5'($urandom); FlushE = 1'($urandom);
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_regwrite"}, 32'(RegWriteM), 0);
    check({tag, "_memwrite"}, 32'(MemWriteM), 0);
    check({tag, "_resultsrc"}, 32'(ResultSrcM), 0);
    check({tag, "_aluresult"}, 32'(ALUResultM), 0);
    check({tag, "_writedata"}, 32'(WriteDataM), 0);
    check({tag, "_pcplus1"}, 32'(PCPlus1M), 0);
    check({tag, "_rd"}, 32'(RdM), 0);
  endtask

  task automatic alu_op(input logic [2:0] op, input string tag, input logic [18:0] exp);
    ALUControlE = op;
    tick();
    check(tag, 32'(ALUResultM), 32'(exp));
  endtask

  initial begin
    bubble();
    reset = 1;
    // Reset with random inputs for two edges
    #1;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    check_m_zero("reset");
    check("reset_cnt", 32'(dut.squash_cnt), 0);
    reset = 0;
    bubble();
    #1;
    check("reset_pcsrc", 32'(PCSrcE), 0);

    // ALU sweep: A=0x7FFFF (-1), B=1
    RD1E = 19'h7FFFF; RD2E = 19'd1; RDE = 5'd7; RegWriteE = 1;
    ResultSrcE = 2'b01; PCE = 15'h0100;
    alu_op(3'b000, "add", 19'h00000);
    check("add_writedata", 32'(WriteDataM), 32'h1);
    check("add_rd", 32'(RdM), 7);
    check("add_regwrite", 32'(RegWriteM), 1);
    check("add_resultsrc", 32'(ResultSrcM), 1);
    check("add_pcplus1", 32'(PCPlus1M), 32'h0101);
    alu_op(3'b001, "sub", 19'h7FFFE);
    alu_op(3'b010, "and", 19'h00001);
    alu_op(3'b011, "or",  19'h7FFFF);
    alu_op(3'b100, "xor", 19'h7FFFE);
    alu_op(3'b101, "sll", 19'h7FFFE);
    alu_op(3'b110, "srl", 19'h3FFFF);
    alu_op(3'b111, "slt", 19'h00001);
    RD1E = 19'd1; RD2E = 19'h7FFFF;
    alu_op(3'b111, "slt_false", 19'h00000);

    // Immediate shifts, including the out-of-range boundary
    bubble();
    ALUSrcE = 1; RD1E = 19'd1; RD2E = 19'h12345;
    ImmExtE = 19'd19;
    alu_op(3'b101, "sll_19", 19'h00000);
    ImmExtE = 19'd18;
    alu_op(3'b101, "sll_18", 19'h40000);
    check("imm_writedata", 32'(WriteDataM), 32'h12345);
    RD1E = 19'h40000; ImmExtE = 19'd18;
    alu_op(3'b110, "srl_18", 19'h00001);
    ImmExtE = 19'd31;
    alu_op(3'b110, "srl_31", 19'h00000);

    // Taken branch then two squash slots, then a normal write
    bubble();
    BranchE = 1; RD1E = 19'd5; RD2E = 19'd5; PCE = 15'h0010; ImmExtE = 19'h00008;
    ALUControlE = 3'b001;
    #1;
    check("br_pcsrc", 32'(PCSrcE), 1);
    check("br_target", 32'(PCTargetE), 32'h0018);
    tick();
    check("br_cnt", 32'(dut.squash_cnt), 2);
    bubble();
    RegWriteE = 1; RDE = 5'd3; RD1E = 19'd10; RD2E = 19'd20; PCE = 15'h0011;
    tick();
    check("slot1_regwrite", 32'(RegWriteM), 0);
    check("slot1_alu", 32'(ALUResultM), 0);
    check("slot1_rd", 32'(RdM), 0);
    PCE = 15'h0012;
    tick();
    check("slot2_regwrite", 32'(RegWriteM), 0);
    check("slot2_cnt", 32'(dut.squash_cnt), 0);
    PCE = 15'h0018;
    tick();
    check("after_regwrite", 32'(RegWriteM), 1);
    check("after_rd", 32'(RdM), 3);
    check("after_alu", 32'(ALUResultM), 30);
    check("after_pcplus1", 32'(PCPlus1M), 32'h0019);

    // Jump with target wrap, then a taken branch in a squash slot
    bubble();
    JumpE = 1; PCE = 15'h7FFE; ImmExtE = 19'd3;
    #1;
    check("jmp_pcsrc", 32'(PCSrcE), 1);
    check("jmp_target", 32'(PCTargetE), 32'h0001);
    tick();
    check("jmp_pcplus1", 32'(PCPlus1M), 32'h7FFF);
    bubble();
    BranchE = 1; RD1E = 19'd9; RD2E = 19'd9; PCE = 15'h7FFF; RegWriteE = 1;
    #1;
    check("sq_br_pcsrc", 32'(PCSrcE), 0);
    tick();
    check("sq_br_cnt", 32'(dut.squash_cnt), 1);
    check("sq_br_regwrite", 32'(RegWriteM), 0);
    bubble();
    tick();
    check("sq_end_cnt", 32'(dut.squash_cnt), 0);
    // Jump at PC 0x7FFF resolves normally and PC+1 wraps to 0
    JumpE = 1; PCE = 15'h7FFF; ImmExtE = 19'd2;
    #1;
    check("jmp2_pcsrc", 32'(PCSrcE), 1);
    check("jmp2_target", 32'(PCTargetE), 32'h0001);
    tick();
    check("jmp2_pcplus1", 32'(PCPlus1M), 0);
    bubble();
    // FlushE during squash still decrements
    FlushE = 1;
    tick();
    check("flush_dec_cnt", 32'(dut.squash_cnt), 1);
    bubble();
    tick();

    // FlushE kills a store and a jump
    MemWriteE = 1; JumpE = 1; FlushE = 1; RD2E = 19'h00ABC; PCE = 15'h0040;
    #1;
    check("flush_pcsrc", 32'(PCSrcE), 0);
    tick();
    check("flush_memwrite", 32'(MemWriteM), 0);
    check("flush_writedata", 32'(WriteDataM), 0);
    check("flush_cnt", 32'(dut.squash_cnt), 0);
    FlushE = 0;
    tick();
    check("store_memwrite", 32'(MemWriteM), 1);
    check("store_writedata", 32'(WriteDataM), 32'h00ABC);
    // that unflushed jump redirected; drain its slots
    bubble();
    tick();
    tick();

    // Reset mid-squash
    JumpE = 1; PCE = 15'h0200;
    tick();
    check("pre_rst_cnt", 32'(dut.squash_cnt), 2);
    bubble();
    reset = 1;
    tick();
    check("rst_mid_cnt", 32'(dut.squash_cnt), 0);
    check("rst_mid_regwrite", 32'(RegWriteM), 0);
    reset = 0;
    RegWriteE = 1; RDE = 5'd9; RD1E = 19'd4; RD2E = 19'd6;
    tick();
    check("post_rst_regwrite", 32'(RegWriteM), 1);
    check("post_rst_rd", 32'(RdM), 9);
    check("post_rst_alu", 32'(ALUResultM), 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipelined processor, directly downstream of the decode stage. Consumes the decode-to-execute pipeline signals (19-bit operands, 15-bit PC, 5-bit destination), performs the ALU operation, resolves branches and jumps, and registers results into the execute-to-memory pipeline register. The decode stage has no flush input, so this block squashes the wrong-path instructions that reach it after a taken branch or jump.

## Interface
- SQUASH_SLOTS, 2: number of instructions squashed in E after a redirect (range 1–3).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  control from decode register.
- ResultSrcE  in  2  result select (00 ALU, 01 memory, 10 PC+1).
- ALUControlE  in  3  ALU operation.
- RD1E, RD2E, ImmExtE  in  19 each  operand A, operand B / store data, extended immediate.
- PCE  in  15  PC of the instruction in E.
- RDE  in  5  destination register.
- FlushE  in  1  hazard-unit bubble request; squashes the current E instruction.
- PCSrcE  out  1  redirect fetch (combinational).
- PCTargetE  out  15  redirect target (combinational).
- RegWriteM, MemWriteM  out  1 each  registered control.
- ResultSrcM  out  2  registered result select.
- ALUResultM, WriteDataM  out  19 each  registered ALU result and RD2E.
- PCPlus1M  out  15  registered PCE+1.
- RdM  out  5  registered destination.

## Operation
- SrcB = ALUSrcE ? ImmExtE : RD2E; SrcA = RD1E.
- ALUControlE: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL by SrcB[4:0], 110 SRL (logical) by SrcB[4:0], 111 SLT signed (result 1 or 0, zero-extended). Shift amounts ≥19 give 0. All arithmetic is 19-bit wrap-around with no overflow flag.
- ZeroE = (SrcA − SrcB == 0), computed with a dedicated subtractor regardless of ALUControlE.
- PCTargetE = PCE + ImmExtE[14:0], mod 2^15. PCPlus1 = PCE + 1, mod 2^15. Wrap from 0x7FFF gives 0x0000.
- Squash condition: killE = FlushE | (squash_cnt != 0).
- PCSrcE = ~killE & (JumpE | (BranchE & ZeroE)).
- squash_cnt is a 2-bit counter with the following next-state priority:
  - reset: 0.
  - PCSrcE: load SQUASH_SLOTS.
  - squash_cnt != 0: decrement by 1.
  - otherwise: hold 0.
- A branch or jump that is itself squashed never redirects and never reloads the counter.
- FlushE while squash_cnt != 0 still decrements the counter.
- M register: when killE, load a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=00, data fields 0. Otherwise load the computed values.
- No forwarding is performed in this block; operands are used as delivered.

## Timing
- Reset: all M-register outputs and squash_cnt are 0 on the first edge with reset high. PCSrcE is 0 while squash_cnt=0 and the inputs are a bubble.
- Latency: E inputs in cycle t appear on the M outputs after the rising edge ending cycle t (1 cycle).
- PCSrcE and PCTargetE are valid combinationally in the same cycle t. Fetch consumes them at the end of t.
- After a redirect in cycle t, the instructions in E during cycles t+1 … t+SQUASH_SLOTS are squashed. Cycle t+SQUASH_SLOTS+1 is the first target instruction.
- Back-to-back branches: a second branch arriving in a squash slot is killed. A branch arriving at t+SQUASH_SLOTS+1 resolves normally.
- Reset asserted mid-squash clears the counter on that edge. The next instruction is not squashed.

## Test plan
- Reset: hold reset 2 cycles with random inputs -> all M outputs 0, PCSrcE=0, squash_cnt=0.
- ALU sweep: RD1E=0x7FFFF, RD2E=1, ALUSrcE=0 -> ADD result 0x00000, SUB 0x7FFFE, SLT 1 (−1<1), SRL 0x3FFFF. Each appears on ALUResultM one cycle later.
- Immediate/shift: ALUSrcE=1, ImmExtE=19 (0x13), ALUControlE=101, RD1E=0x00001 -> ALUResultM=0.
- Taken branch: BranchE=1, RD1E=RD2E=5, PCE=0x0010, ImmExtE=0x0008 -> PCSrcE=1, PCTargetE=0x0018. The next two instructions (both RegWriteE=1) give RegWriteM=0. The third writes normally.
- Jump wrap plus squashed branch: JumpE=1, PCE=0x7FFE, ImmExtE=3 -> PCTargetE=0x0001. A taken branch in the next cycle -> PCSrcE=0, counter not reloaded.
- FlushE with MemWriteE=1 -> MemWriteM=0, PCSrcE=0. Reset asserted while squash_cnt=2 -> the instruction after reset deasserts is not squashed.
